// File: rtl/lsu_pkg.sv
// Shared types and funct3 decode helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRd0,
    StRd1,
    StWr0,
    StWr1,
    StDone
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_legal(input logic we, input logic [2:0] funct3);
    if (we) return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
           (funct3 == F3_BU) || (funct3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: load extraction/extension and store lane merge
// over a two-word buffer pair.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [2:0]  size,
  input  logic        sign,
  input  logic [63:0] pair,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [63:0] wpair
);

  logic [5:0]  sh;
  logic [63:0] shifted;
  logic [31:0] lane_bits;
  logic [63:0] lane_mask;
  logic [63:0] wdata_sh;

  assign sh      = {offset, 3'b000};
  assign shifted = pair >> sh;

  always_comb begin
    rdata = shifted[31:0];
    case (size)
      3'd1:    rdata = {{24{sign & shifted[7]}}, shifted[7:0]};
      3'd2:    rdata = {{16{sign & shifted[15]}}, shifted[15:0]};
      default: rdata = shifted[31:0];
    endcase
  end

  always_comb begin
    case (size)
      3'd1:    lane_bits = 32'h0000_00ff;
      3'd2:    lane_bits = 32'h0000_ffff;
      default: lane_bits = 32'hffff_ffff;
    endcase
  end

  assign lane_mask = {32'h0, lane_bits} << sh;
  assign wdata_sh  = {32'h0, wdata & lane_bits} << sh;
  assign wpair     = (pair & ~lane_mask) | (wdata_sh & lane_mask);

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store initiator: splits word-straddling accesses and does
// read-modify-write for sub-word or unaligned stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [31:0]       mem_a,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  localparam int unsigned WordW = ADDR_W - 2;

  lsu_state_t        state_q, state_d;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, buf0_q, buf1_q;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [WordW-1:0]  word0, word1;
  logic [1:0]        offset;
  logic [2:0]        size;
  logic              span;
  logic [63:0]       pair;
  logic [31:0]       load_data;
  logic [63:0]       wpair;

  assign word0  = addr_q[ADDR_W-1:2];
  assign word1  = word0 + WordW'(1);
  assign offset = addr_q[1:0];
  assign size   = size_of(f3_q);
  assign span   = (3'(offset) + size) > 3'd4;

  // Bypass the word being read this cycle so load data is ready on DONE entry.
  always_comb begin
    case (state_q)
      StRd0:   pair = {buf1_q, mem_rd};
      StRd1:   pair = {mem_rd, buf0_q};
      default: pair = {buf1_q, buf0_q};
    endcase
  end

  lsu_align u_align (
    .offset (offset),
    .size   (size),
    .sign   (~f3_q[2]),
    .pair   (pair),
    .wdata  (wdata_q),
    .rdata  (load_data),
    .wpair  (wpair)
  );

  always_comb begin
    state_d    = state_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    mem_we     = 1'b0;
    mem_a      = 32'h0;
    mem_wd     = 32'h0;
    resp_valid = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (!is_legal(req_we, req_funct3)) begin
            state_d = StDone;
            rdata_d = 32'h0;
            err_d   = 1'b1;
          end else if (req_we && req_funct3 == F3_W && req_addr[1:0] == 2'b00) begin
            state_d = StWr0;
          end else begin
            state_d = StRd0;
          end
        end
      end
      StRd0: begin
        mem_a = 32'(word0);
        if (span) begin
          state_d = StRd1;
        end else if (we_q) begin
          state_d = StWr0;
        end else begin
          state_d = StDone;
          rdata_d = load_data;
          err_d   = 1'b0;
        end
      end
      StRd1: begin
        mem_a = 32'(word1);
        if (we_q) begin
          state_d = StWr0;
        end else begin
          state_d = StDone;
          rdata_d = load_data;
          err_d   = 1'b0;
        end
      end
      StWr0: begin
        mem_we = 1'b1;
        mem_a  = 32'(word0);
        mem_wd = wpair[31:0];
        if (span) begin
          state_d = StWr1;
        end else begin
          state_d = StDone;
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end
      end
      StWr1: begin
        mem_we  = 1'b1;
        mem_a   = 32'(word1);
        mem_wd  = wpair[63:32];
        state_d = StDone;
        rdata_d = 32'h0;
        err_d   = 1'b0;
      end
      StDone: begin
        resp_valid = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      buf0_q  <= 32'h0;
      buf1_q  <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (state_q == StIdle && req_valid) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == StRd0) buf0_q <= mem_rd;
      if (state_q == StRd1) buf1_q <= mem_rd;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model and a
// response scoreboard.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:15];
  logic        tb_wr = 1'b0;
  logic [3:0]  tb_a = 4'h0;
  logic [31:0] tb_d = 32'h0;
  int          wr_cnt = 0;
  logic [31:0] last_wa = 32'hffff_ffff;

  assign mem_rd = mem[mem_a[3:0]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_a[3:0]] <= mem_wd;
      wr_cnt  <= wr_cnt + 1;
      last_wa <= mem_a;
    end else if (tb_wr) begin
      mem[tb_a] <= tb_d;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    tb_wr = 1'b1;
    tb_a  = a;
    tb_d  = d;
    @(negedge clk);
    tb_wr = 1'b0;
  endtask

  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    exp_t e;
    int   lat;
    logic got;
    sb.push_back('{exp_rdata, exp_err, exp_lat});
    @(negedge clk);
    check({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check({tag, "_ready_busy"}, 32'(req_ready), 32'd0);
      if (resp_valid) got = 1'b1;
    end
    e = sb.pop_front();
    check({tag, "_resp_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(e.lat));
    check({tag, "_rdata"}, resp_rdata, e.rdata);
    check({tag, "_err"}, 32'(resp_err), 32'(e.err));
  endtask

  int wc;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_a", mem_a, 32'h0);

    // Aligned word store then load.
    do_req("sw_aligned", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    check("sw_addr", last_wa, 32'd4);
    check("sw_mem", mem[4], 32'hDEADBEEF);
    do_req("lw_aligned", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    // Byte/halfword loads with sign and zero extension.
    poke(4'd1, 32'h11223344);
    do_req("lb_07", 1'b0, 3'b000, 32'h07, 32'h0, 32'h00000011, 1'b0, 2);
    do_req("lbu_07", 1'b0, 3'b100, 32'h07, 32'h0, 32'h00000011, 1'b0, 2);
    do_req("lb_06", 1'b0, 3'b000, 32'h06, 32'h0, 32'h00000022, 1'b0, 2);
    poke(4'd1, 32'h80000000);
    do_req("lb_neg", 1'b0, 3'b000, 32'h07, 32'h0, 32'hFFFFFF80, 1'b0, 2);
    do_req("lh_neg", 1'b0, 3'b001, 32'h06, 32'h0, 32'hFFFF8000, 1'b0, 2);
    do_req("lhu_06", 1'b0, 3'b101, 32'h06, 32'h0, 32'h00008000, 1'b0, 2);
    repeat (3) @(negedge clk);
    check("rdata_hold", resp_rdata, 32'h00008000);

    // Sub-word store read-modify-write; upper wdata bits must be ignored.
    poke(4'd0, 32'hAABBCCDD);
    do_req("sb_01", 1'b1, 3'b000, 32'h01, 32'hFFFFFF55, 32'h0, 1'b0, 3);
    check("sb_mem", mem[0], 32'hAABB55DD);

    // Word-straddling load and store.
    poke(4'd0, 32'h44332211);
    poke(4'd1, 32'h88776655);
    do_req("lw_span", 1'b0, 3'b010, 32'h03, 32'h0, 32'h77665544, 1'b0, 3);
    do_req("sh_span", 1'b1, 3'b001, 32'h03, 32'h1234BEEF, 32'h0, 1'b0, 5);
    check("sh_span_w0", mem[0], 32'hEF332211);
    check("sh_span_w1", mem[1], 32'h887766BE);

    // Illegal funct3: immediate error response, no memory traffic.
    wc = wr_cnt;
    do_req("ld_ill", 1'b0, 3'b011, 32'h04, 32'h0, 32'h0, 1'b1, 1);
    do_req("st_ill", 1'b1, 3'b100, 32'h04, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
    check("ill_no_write", 32'(wr_cnt), 32'(wc));
    check("ill_mem_intact", mem[1], 32'h887766BE);

    // Reset during WR1 of a spanning store: first word persists, second untouched.
    poke(4'd0, 32'h44332211);
    poke(4'd1, 32'h88776655);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h02;
    req_wdata  = 32'hA1B2C3D4;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("wr1_mem_we", 32'(mem_we), 32'd1);
    check("wr1_mem_a", mem_a, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_mem_we", 32'(mem_we), 32'd0);
    check("rstmid_mem_a", mem_a, 32'h0);
    check("rstmid_mem_wd", mem_wd, 32'h0);
    check("rstmid_ready", 32'(req_ready), 32'd1);
    check("rstmid_resp_valid", 32'(resp_valid), 32'd0);
    check("rstmid_rdata", resp_rdata, 32'h0);
    check("rstmid_err", 32'(resp_err), 32'd0);
    repeat (2) @(negedge clk);
    check("rstmid_w0", mem[0], 32'hC3D42211);
    check("rstmid_w1", mem[1], 32'h88776655);
    rst_n = 1'b1;
    do_req("lw_after_rst", 1'b0, 3'b010, 32'h00, 32'h0, 32'hC3D42211, 1'b0, 2);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
